// File: rtl/conv_cfg_sequencer_if.sv
// conv_cfg_sequencer_if: host request, rescan and shared converter command bus
interface conv_cfg_sequencer_if;
  logic        rescan;
  logic        host_req;
  logic [1:0]  host_target;
  logic [15:0] host_addr;
  logic [15:0] host_data;
  logic        host_ack;
  logic        adc1_trig;
  logic        adc2_trig;
  logic        dac_trig;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic        init_done;
  modport master (
    output rescan, host_req, host_target, host_addr, host_data,
    input  host_ack, adc1_trig, adc2_trig, dac_trig, cmd_addr, cmd_data, busy, init_done
  );
  modport slave (
    input  rescan, host_req, host_target, host_addr, host_data,
    output host_ack, adc1_trig, adc2_trig, dac_trig, cmd_addr, cmd_data, busy, init_done
  );
endinterface

// File: rtl/conv_cfg_sequencer.sv
// conv_cfg_sequencer: replays a boot table of converter register writes, then serves host commands
module conv_cfg_sequencer #(
  parameter int                      NUM_CMDS   = 4,
  parameter logic [34*NUM_CMDS-1:0] INIT_TABLE = {NUM_CMDS{34'h3_0000_0000}},
  parameter int                      POR_DELAY  = 1000,
  parameter int                      SPI_WAIT   = 64
) (
  input logic                 clk,
  input logic                 rst,
  conv_cfg_sequencer_if.slave bus
);
  localparam int IW = NUM_CMDS > 1 ? $clog2(NUM_CMDS) : 1;
  typedef enum logic [2:0] {RST_WAIT, LOAD, TRIG, WAIT, IDLE, HTRIG, HWAIT} state_t;
  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [1:0]  tgt, tgt_n;
  logic [15:0] addr, addr_n, data, data_n;
  logic [2:0]  trig, trig_n;
  logic        ack, ack_n, init, init_n, busy;
  logic [33:0] ent;
  logic        last, por_done, wait_done;
  function automatic logic [2:0] dec(input logic [1:0] t);
    return t == 2'd3 ? 3'b000 : 3'b001 << t;
  endfunction
  assign ent       = INIT_TABLE[34*idx +: 34];
  assign last      = idx == IW'(NUM_CMDS - 1);
  assign por_done  = cnt == 32'(POR_DELAY - 1);
  assign wait_done = cnt == 32'(SPI_WAIT - 1);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    tgt_n   = tgt;
    addr_n  = addr;
    data_n  = data;
    trig_n  = 3'b000;
    ack_n   = 1'b0;
    init_n  = init;
    case (state)
      RST_WAIT: begin
        cnt_n   = por_done ? 32'd0 : cnt + 32'd1;
        state_n = por_done ? LOAD : RST_WAIT;
      end
      LOAD: begin
        tgt_n  = ent[33:32];
        addr_n = ent[31:16];
        data_n = ent[15:0];
        // target 3 entries are skipped without trigger or hold-off
        if (ent[33:32] != 2'd3) state_n = TRIG;
        else if (last) state_n = IDLE;
        else idx_n = idx + 1'b1;
      end
      TRIG: begin
        trig_n  = dec(tgt);
        cnt_n   = 32'd0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n   = wait_done ? 32'd0 : cnt + 32'd1;
        idx_n   = wait_done && !last ? idx + 1'b1 : idx;
        state_n = !wait_done ? WAIT : last ? IDLE : LOAD;
      end
      IDLE: begin
        init_n = 1'b1;
        // rescan wins over a simultaneous host request
        if (bus.rescan) begin
          init_n  = 1'b0;
          idx_n   = '0;
          state_n = LOAD;
        end else if (bus.host_req) begin
          tgt_n   = bus.host_target;
          addr_n  = bus.host_addr;
          data_n  = bus.host_data;
          state_n = HTRIG;
        end
      end
      HTRIG: begin
        ack_n   = 1'b1;
        trig_n  = dec(tgt);
        cnt_n   = 32'd0;
        state_n = tgt == 2'd3 ? IDLE : HWAIT;
      end
      HWAIT: begin
        cnt_n   = wait_done ? 32'd0 : cnt + 32'd1;
        state_n = wait_done ? IDLE : HWAIT;
      end
      default: state_n = RST_WAIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_WAIT;
      cnt   <= 32'd0;
      idx   <= '0;
      tgt   <= 2'd0;
      addr  <= 16'd0;
      data  <= 16'd0;
      trig  <= 3'b000;
      ack   <= 1'b0;
      init  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      tgt   <= tgt_n;
      addr  <= addr_n;
      data  <= data_n;
      trig  <= trig_n;
      ack   <= ack_n;
      init  <= init_n;
      busy  <= state != IDLE;
    end
  end
  assign bus.host_ack  = ack;
  assign bus.adc1_trig = trig[0];
  assign bus.adc2_trig = trig[1];
  assign bus.dac_trig  = trig[2];
  assign bus.cmd_addr  = addr;
  assign bus.cmd_data  = data;
  assign bus.busy      = busy;
  assign bus.init_done = init;
endmodule

// File: tb/tb_conv_cfg_sequencer.sv
// tb_conv_cfg_sequencer: directed checks of boot timing, host arbitration, rescan and reset abort
module tb_conv_cfg_sequencer;
  localparam logic [101:0] TBL_A = {2'd2, 16'h0003, 16'h00FF, 2'd1, 16'h0002, 16'h0001, 2'd0, 16'h0001, 16'h0080};
  localparam logic [101:0] TBL_B = {2'd2, 16'h0003, 16'h00FF, 2'd3, 16'h0002, 16'h0001, 2'd0, 16'h0001, 16'h0080};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = -1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   excl = 0;
  conv_cfg_sequencer_if ia ();
  conv_cfg_sequencer_if ib ();
  conv_cfg_sequencer #(.NUM_CMDS(3), .INIT_TABLE(TBL_A), .POR_DELAY(10), .SPI_WAIT(20))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  conv_cfg_sequencer #(.NUM_CMDS(3), .INIT_TABLE(TBL_B), .POR_DELAY(10), .SPI_WAIT(20))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;
  logic [2:0]  trs [2];
  logic [15:0] adr [2];
  logic [15:0] dat [2];
  logic        ini [2];
  logic        bsy [2];
  assign trs[0] = {ia.dac_trig, ia.adc2_trig, ia.adc1_trig};
  assign trs[1] = {ib.dac_trig, ib.adc2_trig, ib.adc1_trig};
  assign adr[0] = ia.cmd_addr;
  assign adr[1] = ib.cmd_addr;
  assign dat[0] = ia.cmd_data;
  assign dat[1] = ib.cmd_data;
  assign ini[0] = ia.init_done;
  assign ini[1] = ib.init_done;
  assign bsy[0] = ia.busy;
  assign bsy[1] = ib.busy;
  always @(negedge clk) if ($countones(trs[0]) > 1 || $countones(trs[1]) > 1) excl++;
  int          ft [2][3];
  int          ct [2][3];
  logic [15:0] fa [2][3];
  logic [15:0] fd [2][3];
  int          irise [2];
  int          ifall [2];
  logic        pinit [2];
  int          ack_cyc, ack_cnt, bfall, start;
  logic [15:0] ack_a, ack_d;
  logic [2:0]  ack_t;
  bit          arm = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic run_window(input int n);
    for (int d = 0; d < 2; d++) begin
      irise[d] = -1;
      ifall[d] = -1;
      pinit[d] = ini[d];
      for (int t = 0; t < 3; t++) begin
        ft[d][t] = -1;
        ct[d][t] = 0;
        fa[d][t] = 16'h0;
        fd[d][t] = 16'h0;
      end
    end
    ack_cyc = -1;
    ack_cnt = 0;
    bfall   = -1;
    ack_a   = 16'h0;
    ack_d   = 16'h0;
    ack_t   = 3'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ia.rescan = 1'b0;
      if (arm && cyc == 4) begin
        ia.host_target = 2'd2;
        ia.host_addr   = 16'h0010;
        ia.host_data   = 16'hBEEF;
        ia.host_req    = 1'b1;
        arm = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        for (int t = 0; t < 3; t++) begin
          if (trs[d][t]) begin
            ct[d][t]++;
            if (ft[d][t] < 0) begin
              ft[d][t] = cyc;
              fa[d][t] = adr[d];
              fd[d][t] = dat[d];
            end
          end
        end
        if (ini[d] && !pinit[d] && irise[d] < 0) irise[d] = cyc;
        if (!ini[d] && pinit[d] && ifall[d] < 0) ifall[d] = cyc;
        pinit[d] = ini[d];
      end
      if (bfall < 0 && ack_cyc >= 0 && !bsy[0]) bfall = cyc;
      if (ia.host_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = cyc;
          ack_a   = ia.cmd_addr;
          ack_d   = ia.cmd_data;
          ack_t   = trs[0];
        end
        ia.host_req = 1'b0;
      end
    end
  endtask
  initial begin
    ia.rescan = 1'b0; ia.host_req = 1'b0; ia.host_target = 2'd0; ia.host_addr = 16'h0; ia.host_data = 16'h0;
    ib.rescan = 1'b0; ib.host_req = 1'b0; ib.host_target = 2'd0; ib.host_addr = 16'h0; ib.host_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_outs_a", {ia.host_ack, trs[0], ia.cmd_addr, ia.cmd_data, ia.busy, ia.init_done}, 64'd0);
    chk("rst_outs_b", {ib.host_ack, trs[1], ib.cmd_addr, ib.cmd_data, ib.busy, ib.init_done}, 64'd0);
    rst = 1'b0;
    arm = 1'b1;
    run_window(110);
    chk("boot_adc1_cyc", ft[0][0], 11);
    chk("boot_adc1_addr", fa[0][0], 16'h0001);
    chk("boot_adc1_data", fd[0][0], 16'h0080);
    chk("boot_adc2_cyc", ft[0][1], 33);
    chk("boot_adc2_addr", fa[0][1], 16'h0002);
    chk("boot_dac_cyc", ft[0][2], 55);
    chk("boot_dac_data", fd[0][2], 16'h00FF);
    chk("boot_init_rise", irise[0], 76);
    chk("host_ack_cnt", ack_cnt, 1);
    chk("host_ack_cyc", ack_cyc, 77);
    chk("host_ack_trig", ack_t, 3'b100);
    chk("host_ack_addr", ack_a, 16'h0010);
    chk("host_ack_data", ack_d, 16'hBEEF);
    chk("host_busy_fall", bfall, 98);
    chk("host_dac_cnt", ct[0][2], 2);
    chk("skip_adc1_cyc", ft[1][0], 11);
    chk("skip_adc2_cnt", ct[1][1], 0);
    chk("skip_dac_cyc", ft[1][2], 34);
    chk("skip_init_rise", irise[1], 55);
    start = cyc;
    ia.host_target = 2'd3;
    ia.host_addr   = 16'h0055;
    ia.host_data   = 16'h0000;
    ia.host_req    = 1'b1;
    run_window(4);
    chk("t3_ack_cnt", ack_cnt, 1);
    chk("t3_ack_lat", ack_cyc - start, 2);
    chk("t3_ack_trig", ack_t, 3'b000);
    chk("t3_trig_cnt", ct[0][0] + ct[0][1] + ct[0][2], 0);
    chk("t3_idle_next", bfall - ack_cyc, 1);
    start = cyc + 1;
    ia.rescan      = 1'b1;
    ia.host_target = 2'd2;
    ia.host_addr   = 16'h0020;
    ia.host_data   = 16'h1234;
    ia.host_req    = 1'b1;
    run_window(95);
    chk("rs_init_fall", ifall[0] - start, 0);
    chk("rs_adc1_rel", ft[0][0] - start, 2);
    chk("rs_adc2_rel", ft[0][1] - start, 24);
    chk("rs_dac_rel", ft[0][2] - start, 46);
    chk("rs_init_rise", irise[0] - start, 67);
    chk("rs_ack_rel", ack_cyc - start, 68);
    chk("rs_ack_cnt", ack_cnt, 1);
    chk("rs_ack_trig", ack_t, 3'b100);
    chk("rs_ack_addr", ack_a, 16'h0020);
    chk("rs_busy_rel", bfall - start, 89);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_window(40);
    chk("mr_adc2_cyc", ft[0][1], 33);
    rst = 1'b1;
    #1;
    chk("mr_async_a", {ia.host_ack, trs[0], ia.cmd_addr, ia.cmd_data, ia.busy, ia.init_done}, 64'd0);
    chk("mr_async_b", {ib.host_ack, trs[1], ib.cmd_addr, ib.cmd_data, ib.busy, ib.init_done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_window(15);
    chk("mr_adc1_cyc", ft[0][0], 11);
    chk("mr_adc1_addr", fa[0][0], 16'h0001);
    chk("mr_adc2_cnt", ct[0][1], 0);
    chk("trig_onehot", excl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_cfg_sequencer.md
Name: conv_cfg_sequencer

Overview:
Power-up and runtime configuration sequencer for the converter board. It drives the command ports (cmd_trig/cmd_addr/cmd_data) of the two LTC2195 ADC drivers and the AD9783 DAC driver, which otherwise sit tied off. After reset it walks a parameterised boot table of register writes, then arbitrates single host-issued commands onto the same shared address/data bus.

Parameters:
NUM_CMDS, 4, number of boot-table entries (1..64)
INIT_TABLE, {NUM_CMDS{34'h3_0000_0000}}, flat table; entry i at bits [34*i+33:34*i] = {target[1:0], addr[15:0], data[15:0]}
POR_DELAY, 1000, clk_in cycles to wait after reset release before the first command (>=1)
SPI_WAIT, 64, clk_in cycles to hold off after each trigger, covering one driver SPI transaction (>=1)

Ports:
clk_in  input  1  system clock (100 MHz, BUFG)
rst_in  input  1  asynchronous active-high reset
rescan_in  input  1  single-cycle pulse: replay the boot table
host_req_in  input  1  host command request, level, held until ack
host_target_in  input  2  0=ADC1, 1=ADC2, 2=DAC, 3=none
host_addr_in  input  16  host register address
host_data_in  input  16  host register data
host_ack_out  output  1  one-cycle pulse: host command accepted
adc1_cmd_trig_out  output  1  trigger to ADC1 driver
adc2_cmd_trig_out  output  1  trigger to ADC2 driver
dac_cmd_trig_out  output  1  trigger to DAC driver
cmd_addr_out  output  16  shared command address to all drivers
cmd_data_out  output  16  shared command data to all drivers
busy_out  output  1  high in every state except IDLE
init_done_out  output  1  high once the boot table has completed

Behaviour:
- Reset (async assert, sync release): all outputs 0; state RST_WAIT; counter=0; index=0. Asserting reset mid-operation aborts immediately, and the full sequence restarts after release.
- States: RST_WAIT, LOAD, TRIG, WAIT, IDLE, HTRIG, HWAIT.
- RST_WAIT: count POR_DELAY cycles, then go to LOAD.
- LOAD: register table entry[index] addr/data onto cmd_addr_out/cmd_data_out.
  - target!=3: go to TRIG.
  - target==3: skip. index++; go to LOAD, or to IDLE if index==NUM_CMDS. No trigger and no wait.
- TRIG: exactly one trigger output high for one cycle. The target is decoded from the entry. addr/data are stable from the previous cycle. Go to WAIT.
- WAIT: SPI_WAIT cycles, then index++; go to LOAD, or to IDLE when index==NUM_CMDS.
- Timing:
  - First trigger is high in cycle POR_DELAY+1 after reset release (cycle 0 = first edge after release).
  - Consecutive non-skipped triggers are spaced SPI_WAIT+2 cycles apart.
- Entering IDLE from the boot table sets init_done_out=1. It is cleared only by reset or by rescan.
- IDLE, rescan_in=1: index=0, init_done_out=0, go to LOAD (no POR_DELAY). rescan_in is ignored in every other state.
- IDLE, host_req_in=1 (and no rescan): latch target/addr/data; drive cmd_addr_out/cmd_data_out; go to HTRIG.
- HTRIG: host_ack_out=1 for one cycle.
  - Same cycle, the decoded trigger is pulsed if target!=3.
  - target==3: return to IDLE; ack only, no trigger.
  - Otherwise go to HWAIT.
- HWAIT: SPI_WAIT cycles, then IDLE.
- Host arbitration:
  - host_req_in during the boot sequence is held off: no ack until IDLE.
  - rescan_in and host_req_in in the same IDLE cycle: rescan wins; the host is served after the table completes.
  - A request still high in IDLE after its ack is treated as a new request. The host must drop req on the cycle after ack.
- cmd_addr_out/cmd_data_out hold their last value outside LOAD/HTRIG. They never change during TRIG or WAIT.
- Trigger outputs are mutually exclusive; at most one is high in any cycle.
- busy_out = (state != IDLE), registered.
- NUM_CMDS entries are all target 3: init_done_out rises with no triggers after POR_DELAY+NUM_CMDS+1 cycles.

Test Plan:
- POR_DELAY=10, SPI_WAIT=20, NUM_CMDS=3, table = {ADC1 0x0001/0x0080, ADC2 0x0002/0x0001, DAC 0x0003/0x00FF}. Release reset -> adc1 trig at cycle 11 with addr 0x0001/data 0x0080; adc2 trig at cycle 33; dac trig at cycle 55; init_done_out rises at cycle 76.
- Middle entry target=3 -> no adc2 trig; the dac trig moves to cycle 34; no extra wait is inserted.
- host_req_in held high from cycle 5 with DAC 0x0010/0xBEEF -> no ack until IDLE. Then one ack coincides with dac_cmd_trig_out, addr=0x0010, data=0xBEEF; busy_out drops 21 cycles later.
- Host request with target=3 in IDLE -> host_ack_out pulses, no trigger outputs, back to IDLE the next cycle.
- rescan_in and host_req_in asserted in the same IDLE cycle -> init_done_out falls, the full table replays, then the host is acked.
- rst_in asserted during WAIT of entry 1 -> all outputs 0 asynchronously. After release, the sequence restarts from entry 0 with the full POR_DELAY.
